// File: rtl/wb_arbiter_pkg.sv
// Shared constants for the writeback arbiter: FU indices, default widths and a pointer-width helper.
package wb_arbiter_pkg;
  localparam int FU_ALU  = 0;
  localparam int FU_JUMP = 1;
  localparam int FU_MEM  = 2;
  localparam int FU_MUL  = 3;
  localparam int FU_DIV  = 4;

  localparam int NUM_FU_DEF = 5;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W_DEF = 32;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/wb_arbiter_if.sv
// FU-to-writeback bus. WB_FWD_EN adds the forwarding outputs.
interface wb_arbiter_if
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_FU = NUM_FU_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = REG_ADDR_W
);
  logic [NUM_FU-1:0]             req_valid;
  logic [NUM_FU-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_FU-1:0][DATA_W-1:0] req_data;
  logic [NUM_FU-1:0]             req_ready;
  logic                          wb_stall;
  logic [NUM_FU-1:0]             wt_en;
  logic [ADDR_W-1:0]             wt_addr;
  logic [DATA_W-1:0]             wt_data;
  logic [NUM_FU-1:0]             done;
`ifdef WB_FWD_EN
  logic                          fwd_valid;
  logic [ADDR_W-1:0]             fwd_addr;
  logic [DATA_W-1:0]             fwd_data;

  modport master (output req_valid, req_addr, req_data, wb_stall,
                  input  req_ready, wt_en, wt_addr, wt_data, done,
                         fwd_valid, fwd_addr, fwd_data);
  modport slave  (input  req_valid, req_addr, req_data, wb_stall,
                  output req_ready, wt_en, wt_addr, wt_data, done,
                         fwd_valid, fwd_addr, fwd_data);
`else
  modport master (output req_valid, req_addr, req_data, wb_stall,
                  input  req_ready, wt_en, wt_addr, wt_data, done);
  modport slave  (input  req_valid, req_addr, req_data, wb_stall,
                  output req_ready, wt_en, wt_addr, wt_data, done);
`endif
endinterface

// File: rtl/wb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: search starts at ptr and wraps; returns one-hot grant and next pointer.
module rr_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int N  = NUM_FU_DEF,
  parameter int PW = ptr_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] ptr_nxt
);
  // Walk from the farthest candidate to the nearest so the nearest valid one wins.
  always_comb begin
    int idx;
    gnt     = '0;
    ptr_nxt = ptr;
    idx     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N;
      if (req[idx[PW-1:0]]) begin
        gnt                = '0;
        gnt[idx[PW-1:0]]   = 1'b1;
        ptr_nxt            = PW'((idx + 1) % N);
      end
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Round-robin writeback arbiter with one registered output stage.
// Optional macro WB_FWD_EN exposes the output stage as fwd_valid/fwd_addr/fwd_data.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NUM_FU = NUM_FU_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = REG_ADDR_W
) (
  input logic         clk,
  input logic         rst,
  wb_arbiter_if.slave bus
);
  localparam int PW = ptr_w(NUM_FU);

  logic [PW-1:0]     ptr, ptr_nxt;
  logic [NUM_FU-1:0] req, gnt;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] data_sel;

  // Reset and stall both mask requests so no grant can leak out combinationally.
  assign req = bus.req_valid & {NUM_FU{rst & ~bus.wb_stall}};

  rr_arbiter #(.N(NUM_FU), .PW(PW)) u_rr (
    .req     (req),
    .ptr     (ptr),
    .gnt     (gnt),
    .ptr_nxt (ptr_nxt)
  );

  assign bus.req_ready = gnt;

  always_comb begin
    addr_sel = '0;
    data_sel = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (gnt[k]) begin
        addr_sel = addr_sel | bus.req_addr[k];
        data_sel = data_sel | bus.req_data[k];
      end
    end
  end

  // Address 0 is hardwired: still consumed and reported done, never written.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr         <= '0;
      bus.done    <= '0;
      bus.wt_en   <= '0;
      bus.wt_addr <= '0;
      bus.wt_data <= '0;
    end else begin
      ptr         <= ptr_nxt;
      bus.done    <= gnt;
      bus.wt_en   <= (addr_sel != '0) ? gnt : '0;
      bus.wt_addr <= addr_sel;
      bus.wt_data <= data_sel;
    end
  end

`ifdef WB_FWD_EN
  assign bus.fwd_valid = |bus.wt_en;
  assign bus.fwd_addr  = bus.wt_addr;
  assign bus.fwd_data  = bus.wt_data;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed + randomized bench for wb_arbiter against a round-robin reference model and a negedge register file.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  localparam int NF = 5;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk, rst;
  logic [NF-1:0]         v;
  logic [NF-1:0][AW-1:0] a;
  logic [NF-1:0][DW-1:0] d;
  logic                  s;

  wb_arbiter_if #(.NUM_FU(NF), .DATA_W(DW), .ADDR_W(AW)) bus ();

  assign bus.req_valid = v;
  assign bus.req_addr  = a;
  assign bus.req_data  = d;
  assign bus.wb_stall  = s;

  wb_arbiter #(.NUM_FU(NF), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file that captures on the falling edge inside the output cycle.
  logic [DW-1:0] rf [32] = '{default: '0};
  always @(negedge clk) begin
    for (int k = 0; k < NF; k++)
      if (bus.wt_en[k]) rf[bus.wt_addr] <= bus.wt_data;
  end

  int tests = 0;
  int fails = 0;

  // Reference model state
  int            mptr;
  logic [DW-1:0] mrf [32];
  logic          pend_v;
  logic [AW-1:0] pend_a;
  logic [DW-1:0] pend_d;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs are already driven; check ready before the edge, outputs after it.
  task automatic step(output int g);
    logic [NF-1:0] er, ee;
    #2;
    g = -1;
    if (!s)
      for (int i = 0; i < NF; i++) begin
        int k = (mptr + i) % NF;
        if (g < 0 && v[k]) g = k;
      end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    ee = (g >= 0 && a[g] != '0) ? er : '0;
    chk("req_ready", bus.req_ready, er);
    @(posedge clk);
    #1;
    if (pend_v) mrf[pend_a] = pend_d;
    pend_v = 1'b0;
    chk("done", bus.done, er);
    chk("wt_en", bus.wt_en, ee);
`ifdef WB_FWD_EN
    chk("fwd_valid", bus.fwd_valid, |ee);
`endif
    if (g >= 0) begin
      chk("wt_addr", bus.wt_addr, a[g]);
      chk("wt_data", bus.wt_data, d[g]);
`ifdef WB_FWD_EN
      chk("fwd_addr", bus.fwd_addr, a[g]);
      chk("fwd_data", bus.fwd_data, d[g]);
`endif
      pend_v = (a[g] != '0);
      pend_a = a[g];
      pend_d = d[g];
      mptr   = (g + 1) % NF;
    end
  endtask

  // Asynchronous reset taken mid-cycle; outputs must clear without an edge.
  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_wt_en", bus.wt_en, '0);
    chk("rst_done", bus.done, '0);
    chk("rst_ready", bus.req_ready, '0);
    chk("rst_wt_addr", bus.wt_addr, '0);
    chk("rst_wt_data", bus.wt_data, '0);
    mptr   = 0;
    pend_v = 1'b0;
    @(negedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    int g;
    rst = 1'b1; s = 1'b0; v = '0; a = '0; d = '0;
    mptr = 0; pend_v = 1'b0; pend_a = '0; pend_d = '0;
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    do_reset();

    // Single ALU result right after reset.
    v = 5'b00001; a[FU_ALU] = 5'd3; d[FU_ALU] = 32'hDEADBEEF;
    step(g);
    v = '0;
    step(g);
    chk("rf3", rf[3], 32'hDEADBEEF);

    // All FUs valid: one grant per cycle, wrapping back to 0.
    do_reset();
    for (int k = 0; k < NF; k++) begin a[k] = AW'(k + 10); d[k] = 32'h100 + k; end
    v = '1;
    for (int c = 0; c < 6; c++) step(g);
    v = '0;
    step(g);

    // Write to register 0 is suppressed but still reported done.
    v = 5'b00001; a[FU_ALU] = '0; d[FU_ALU] = 32'd7;
    step(g);
    v = '0;
    step(g);
    chk("rf0", rf[0], '0);

    // Stall blocks grants; MUL goes the first cycle after release.
    s = 1'b1; v = 5'b01000; a[FU_MUL] = 5'd12; d[FU_MUL] = 32'hC0FFEE;
    for (int c = 0; c < 3; c++) step(g);
    s = 1'b0;
    step(g);
    v = '0;
    step(g);

    // Reset lands while MUL's write is in the output stage.
    v = 5'b01000; a[FU_MUL] = 5'd21; d[FU_MUL] = 32'h5A5A0001;
    step(g);
    do_reset();
    step(g);
    v = '0;
    step(g);
    chk("rf21", rf[21], 32'h5A5A0001);

    // MEM and DIV collide on register 9: MEM first, DIV last wins.
    do_reset();
    v = 5'b10100;
    a[FU_MEM] = 5'd9; d[FU_MEM] = 32'd1;
    a[FU_DIV] = 5'd9; d[FU_DIV] = 32'd2;
    step(g);
    v[g] = 1'b0;
    step(g);
    v[g] = 1'b0;
    step(g);
    chk("rf9", rf[9], 32'd2);

    // Random traffic: FUs reload after being consumed, stalls sprinkled in.
    for (int c = 0; c < 300; c++) begin
      s = ($urandom_range(0, 5) == 0);
      for (int k = 0; k < NF; k++)
        if (!v[k] && $urandom_range(0, 2) != 0) begin
          v[k] = 1'b1;
          a[k] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(0, 31));
          d[k] = $urandom;
        end
      step(g);
      if (g >= 0) v[g] = 1'b0;
    end
    s = 1'b0; v = '0;
    step(g);
    step(g);
    for (int i = 0; i < 32; i++) chk($sformatf("rf_final[%0d]", i), rf[i], mrf[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_FU, default 5, number of functional units; index order 0=ALU, 1=JUMP, 2=MEM, 3=MUL, 4=DIV.
REQ-002 SHALL have parameter DATA_W, default 32, result data width.
REQ-003 SHALL have parameter ADDR_W, default 5, destination register address width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  NUM_FU  FU k holds a completed result.
REQ-007 req_addr  input  NUM_FU*ADDR_W  destination register per FU; slice k belongs to FU k.
REQ-008 req_data  input  NUM_FU*DATA_W  result data per FU; slice k belongs to FU k.
REQ-009 req_ready  output  NUM_FU  one-hot grant; the FU result is consumed when valid and ready are both high.
REQ-010 wb_stall  input  1  suppresses all new grants while high.
REQ-011 wt_en  output  NUM_FU  per-FU register-file write strobe (drives L_S_<FU>).
REQ-012 wt_addr  output  ADDR_W  write address shared by all FU write ports.
REQ-013 wt_data  output  DATA_W  write data shared by all FU write ports.
REQ-014 done  output  NUM_FU  one-cycle pulse per FU, used by the scoreboard to release that FU.

Function
REQ-015 SHALL assert at most one req_ready bit per cycle; req_ready is combinational from req_valid, wb_stall and the priority pointer.
REQ-016 SHALL arbitrate round-robin: the search starts at index ptr and wraps from NUM_FU-1 to 0; the first valid FU found is granted.
REQ-017 SHALL set ptr to (k+1) mod NUM_FU on the edge after a grant to FU k; ptr holds when there is no grant.
REQ-018 SHALL grant nothing while wb_stall=1; in that case ptr holds and the output stage empties on the next edge.
REQ-019 SHALL register a grant into the output stage: a grant in cycle N gives wt_en[k]=1, wt_addr and wt_data in cycle N+1, for exactly one cycle.
REQ-020 The register file SHALL be able to capture on the falling edge inside cycle N+1; outputs SHALL stay stable for the whole of cycle N+1.
REQ-021 SHALL pulse done[k] in cycle N+1 for every grant to FU k, including grants to address 0.
REQ-022 SHALL hold wt_en=0 when the granted req_addr is 0; wt_addr and wt_data are still registered.
REQ-023 SHALL sustain back-to-back grants, one per cycle, with no bubble cycles.
REQ-024 When two FUs target the same address in the same cycle, SHALL write them in round-robin grant order, one per cycle; the later write wins.
REQ-025 SHALL hold wt_en=0 and done=0 in every cycle that follows a cycle with no grant.

Reset
REQ-026 With rst=0, SHALL immediately clear wt_en, done, wt_addr, wt_data and ptr to 0, with no clock edge required.
REQ-027 SHALL drive req_ready=0 while rst=0; a reset mid-operation drops any in-flight write, and the FU keeps its valid asserted.
REQ-028 SHALL allow the first grant in the first cycle after rst returns to 1, starting with FU 0.

Configuration
REQ-029 Macro WB_FWD_EN defined: SHALL add outputs fwd_valid (1), fwd_addr (ADDR_W) and fwd_data (DATA_W), equal to the registered output stage.
REQ-030 Under WB_FWD_EN, fwd_valid SHALL equal OR(wt_en), so fwd_valid=0 for address 0; the fwd outputs are reset to 0.
REQ-031 Macro WB_FWD_EN undefined: the fwd ports SHALL be absent, and all other behaviour is unchanged.

Structure
REQ-032 Shared package SHALL hold the FU index constants (FU_ALU..FU_DIV), the NUM_FU default and the register address width.
REQ-033 SHALL instantiate one sub-module, rr_arbiter (request vector plus pointer in, one-hot grant plus next pointer out), which is purely combinational.

Verification
REQ-034 After reset, req_valid=5'b00001, addr 3, data 32'hDEADBEEF -> ready[0] in cycle 0; wt_en=5'b00001, wt_addr=3, wt_data=DEADBEEF and done[0] in cycle 1 only.
REQ-035 req_valid=5'b11111 held for 5 cycles, ptr=0 -> grants in order 0,1,2,3,4, then 0 on the 6th cycle; no idle cycles.
REQ-036 ALU with addr 0, data 7 -> done[0]=1, wt_en=0; register 0 stays unchanged.
REQ-037 wb_stall=1 for 3 cycles with req_valid=5'b01000 -> ready=0 and wt_en=0 throughout; grant to FU 3 in the first cycle after wb_stall=0.
REQ-038 rst asserted in the cycle after a grant to MUL -> wt_en and done clear immediately; after release, MUL is re-granted and the write completes.
REQ-039 MEM and DIV both target addr 9 (data 1 and 2), ptr=0 -> writes in the order MEM then DIV; register 9 ends at 2.
